// File: rtl/alu_pkg.sv
// Shared encodings for param_alu: opcodes, status-bit positions, FSM states
// and the status-byte packing helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_INV  = 4'd7,
    OP_TWC  = 4'd8,
    OP_INC  = 4'd9,
    OP_DEC  = 4'd10,
    OP_SEB  = 4'd11,
    OP_CLB  = 4'd12,
    OP_PASS = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIV  = 4'd15
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_T = 3;
  localparam int FLAG_V = 4;
  localparam int FLAG_S = 5;
  localparam int FLAG_1 = 6;
  localparam int FLAG_I = 7;

  // T and I pass straight through from the incoming status register
  localparam logic [7:0] KEEP_MASK = (8'h01 << FLAG_T) | (8'h01 << FLAG_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [7:0] f;
    f         = 8'h00;
    f[FLAG_1] = 1'b1;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_S] = n ^ v;
    return f;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// o_hi/o_lo show the state after the current iteration, valid with o_done.
module seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic             r_active;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_next_acc;
  logic [WIDTH-1:0] w_next_q;

  // One multiply or divide step from the current accumulator/shift register
  always_comb begin
    w_add      = {1'b0, r_acc};
    w_shift    = {r_acc, r_q[WIDTH-1]};
    w_diff     = w_shift[WIDTH-1:0] - r_m;
    w_next_acc = r_acc;
    w_next_q   = r_q;
    if (r_mode) begin
      if (w_shift >= {1'b0, r_m}) begin
        w_next_acc = w_diff;
        w_next_q   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_next_acc = w_shift[WIDTH-1:0];
        w_next_q   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (r_q[0]) begin
        w_add = {1'b0, r_acc} + {1'b0, r_m};
      end else begin
        w_add = {1'b0, r_acc};
      end
      w_next_acc = w_add[WIDTH:1];
      w_next_q   = {w_add[0], r_q[WIDTH-1:1]};
    end
  end

  assign o_done = r_active && (r_cnt == LAST_CNT);
  assign o_hi   = w_next_acc;
  assign o_lo   = w_next_q;

  // Load operands on start, then iterate WIDTH times
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_mode   <= i_mode;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= i_mode ? i_a : i_b;
      r_m      <= i_mode ? i_b : i_a;
    end else if (r_active) begin
      r_acc <= w_next_acc;
      r_q   <= w_next_q;
      if (o_done) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_alu.sv
// Handshaked ALU: single-cycle ops plus iterative MUL/DIV, with registered
// result pair and status byte held until writeback accepts them.
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] bit_idx,
  input  logic [7:0]               status_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result_lo,
  output logic [WIDTH-1:0]         result_hi,
  output logic [7:0]               status_out,
  output logic                     busy
);

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_result_lo;
  logic [WIDTH-1:0] r_result_hi;
  logic [7:0]       r_status;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_div;
  logic             r_div_zero;
  logic [7:0]       r_keep;

  logic             w_accept;
  logic             w_is_md;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_bit;
  logic             w_arith;
  logic             w_c;
  logic             w_v;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic [7:0]       w_md_flags;

  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_md    = (op == OP_MUL) || (op == OP_DIV);
  assign w_bit      = WIDTH'(1) << bit_idx;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign result_lo  = r_result_lo;
  assign result_hi  = r_result_hi;
  assign status_out = r_status;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_accept && w_is_md),
    .i_mode (op == OP_DIV),
    .i_a    (a),
    .i_b    (b),
    .o_done (w_md_done),
    .o_hi   (w_md_hi),
    .o_lo   (w_md_lo)
  );

  // Single-cycle datapath: arithmetic runs on WIDTH+1 bits, bit WIDTH is C
  always_comb begin
    w_ext   = '0;
    w_res   = a;
    w_arith = 1'b0;
    w_v     = 1'b0;
    case (op)
      OP_ADD: begin w_arith = 1'b1; w_ext = {1'b0, a} + {1'b0, b}; end
      OP_ADC: begin w_arith = 1'b1; w_ext = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(status_in[FLAG_C]); end
      OP_SUB: begin w_arith = 1'b1; w_ext = {1'b0, b} - {1'b0, a}; end
      OP_SBC: begin w_arith = 1'b1; w_ext = {1'b0, b} - {1'b0, a} - (WIDTH+1)'(status_in[FLAG_C]); end
      OP_TWC: begin w_arith = 1'b1; w_ext = '0 - {1'b0, a}; end
      OP_INC: begin w_arith = 1'b1; w_ext = {1'b0, a} + (WIDTH+1)'(1); end
      OP_DEC: begin w_arith = 1'b1; w_ext = {1'b0, a} - (WIDTH+1)'(1); end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_INV: w_res = ~a;
      OP_SEB: w_res = a | w_bit;
      OP_CLB: w_res = a & ~w_bit;
      default: w_res = a;
    endcase
    if (w_arith) begin
      w_res = w_ext[WIDTH-1:0];
    end else begin
      w_res = w_res;
    end
    w_c = w_arith & w_ext[WIDTH];
    // Overflow from operand signs versus result sign
    case (op)
      OP_ADD, OP_ADC: w_v = (a[MSB] == b[MSB]) && (w_ext[MSB] != a[MSB]);
      OP_SUB, OP_SBC: w_v = (a[MSB] != b[MSB]) && (w_ext[MSB] != b[MSB]);
      OP_TWC:         w_v = a[MSB] & w_ext[MSB];
      OP_INC:         w_v = ~a[MSB] & w_ext[MSB];
      OP_DEC:         w_v = a[MSB] & ~w_ext[MSB];
      default:        w_v = 1'b0;
    endcase
  end

  // Flags for the final MUL/DIV iteration
  always_comb begin
    if (r_div) begin
      w_md_flags = pack_flags(w_md_lo == '0, w_md_lo[MSB], 1'b0, r_div_zero);
    end else begin
      w_md_flags = pack_flags({w_md_hi, w_md_lo} == '0, w_md_hi[MSB], 1'b0, w_md_hi != '0);
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_status    <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_div       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_keep      <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept && w_is_md) begin
            r_state     <= ST_BUSY;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
            r_div       <= (op == OP_DIV);
            r_div_zero  <= (b == '0);
            r_keep      <= status_in & KEEP_MASK;
          end else if (w_accept) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result_lo <= w_res;
            r_result_hi <= '0;
            r_status    <= pack_flags(w_res == '0, w_res[MSB], w_c, w_v) | (status_in & KEEP_MASK);
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result_lo <= w_md_lo;
            r_result_hi <= w_md_hi;
            r_status    <= w_md_flags | r_keep;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu (WIDTH=16): directed vector table, random
// ops against an arithmetic reference model, back-pressure and reset sequences.
module tb_param_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  bit_idx;
  logic [7:0]  status_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic [7:0]  status_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  param_alu #(.WIDTH(16), .OPW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .bit_idx(bit_idx), .status_in(status_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo),
    .result_hi(result_hi), .status_out(status_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  idx;
    logic [7:0]  st;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [7:0]  so;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands
  function automatic void model(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                                input logic [3:0] xi, input logic [7:0] xs,
                                output logic [15:0] lo, output logic [15:0] hi, output logic [7:0] so);
    longint ua, ub, sa, sb, cin, r, sr, p;
    logic [63:0] rv;
    logic [63:0] pv;
    bit arith, cf, vf, z, n;
    ua = longint'(xa); ub = longint'(xb);
    sa = longint'($signed(xa)); sb = longint'($signed(xb));
    cin = longint'(xs[2]);
    r = 0; sr = 0; arith = 1'b0; cf = 1'b0; vf = 1'b0;
    hi = 16'h0000;
    case (o)
      OP_ADD: begin r = ua + ub;       sr = sa + sb;       arith = 1'b1; end
      OP_ADC: begin r = ua + ub + cin; sr = sa + sb + cin; arith = 1'b1; end
      OP_SUB: begin r = ub - ua;       sr = sb - sa;       arith = 1'b1; end
      OP_SBC: begin r = ub - ua - cin; sr = sb - sa - cin; arith = 1'b1; end
      OP_TWC: begin r = -ua;           sr = -sa;           arith = 1'b1; end
      OP_INC: begin r = ua + 1;        sr = sa + 1;        arith = 1'b1; end
      OP_DEC: begin r = ua - 1;        sr = sa - 1;        arith = 1'b1; end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_INV: r = (~ua) & 64'hFFFF;
      OP_SEB: r = ua | (64'd1 << xi);
      OP_CLB: r = ua & ~(64'd1 << xi);
      default: r = ua;
    endcase
    rv = r;
    lo = rv[15:0];
    if (arith) begin
      cf = (r < 0) || (r > 65535);
      vf = (sr < -32768) || (sr > 32767);
    end
    z = (lo == 16'h0000);
    n = lo[15];
    if (o == OP_MUL) begin
      p = ua * ub;
      pv = p;
      lo = pv[15:0];
      hi = pv[31:16];
      vf = (hi != 16'h0000);
      z = (p == 0);
      n = hi[15];
    end else if (o == OP_DIV) begin
      if (ub == 0) begin
        lo = 16'hFFFF; hi = xa; vf = 1'b1;
      end else begin
        rv = ua / ub; lo = rv[15:0];
        rv = ua % ub; hi = rv[15:0];
      end
      z = (lo == 16'h0000);
      n = lo[15];
    end
    so = {xs[7], 1'b1, n ^ vf, vf, xs[3], cf, n, z};
  endfunction

  // Issue one op with out_ready high; report result, latency and busy cycles
  task automatic run_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                        input logic [3:0] xi, input logic [7:0] xs,
                        output logic [15:0] lo, output logic [15:0] hi, output logic [7:0] so,
                        output int lat, output int nbusy, output bit ready_in_busy);
    int w;
    op = o; a = xa; b = xb; bit_idx = xi; status_in = xs;
    in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~xa; b = ~xb; op = o ^ 4'hF; status_in = ~xs;
    lat = 1; nbusy = 0; ready_in_busy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy) nbusy++;
      if (busy && in_ready) ready_in_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    lo = result_lo; hi = result_hi; so = status_out;
  endtask

  initial begin
    logic [15:0] lo, hi, elo, ehi, hlo;
    logic [7:0]  so, eso, hso;
    int lat, nbusy;
    bit rib, md, stale;
    logic [3:0] ro;
    logic [15:0] ra, rb;

    // S = N ^ V, so the overflowing ADD sets N and V but not S (0x52)
    vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 4'd0,  8'h00, 16'h8000, 16'h0000, 8'h52};
    vecs[1]  = '{OP_SUB,  16'h0005, 16'h0003, 4'd0,  8'h00, 16'hFFFE, 16'h0000, 8'h66};
    vecs[2]  = '{OP_SBC,  16'h0000, 16'h0000, 4'd0,  8'h04, 16'hFFFF, 16'h0000, 8'h66};
    vecs[3]  = '{OP_MUL,  16'hFFFF, 16'hFFFF, 4'd0,  8'h00, 16'h0001, 16'hFFFE, 8'h52};
    vecs[4]  = '{OP_DIV,  16'd100,  16'd7,    4'd0,  8'h00, 16'd14,   16'd2,    8'h40};
    vecs[5]  = '{OP_DIV,  16'h1234, 16'h0000, 4'd0,  8'h00, 16'hFFFF, 16'h1234, 8'h52};
    vecs[6]  = '{OP_INC,  16'hFFFF, 16'h0000, 4'd0,  8'h88, 16'h0000, 16'h0000, 8'hCD};
    vecs[7]  = '{OP_TWC,  16'h8000, 16'h0000, 4'd0,  8'h00, 16'h8000, 16'h0000, 8'h56};
    vecs[8]  = '{OP_SEB,  16'h0000, 16'h0000, 4'd15, 8'h00, 16'h8000, 16'h0000, 8'h62};
    vecs[9]  = '{OP_CLB,  16'hFFFF, 16'h0000, 4'd0,  8'h00, 16'hFFFE, 16'h0000, 8'h62};
    vecs[10] = '{OP_DEC,  16'h0000, 16'h0000, 4'd0,  8'h00, 16'hFFFF, 16'h0000, 8'h66};
    vecs[11] = '{OP_XOR,  16'h5A5A, 16'h5A5A, 4'd0,  8'hFF, 16'h0000, 16'h0000, 8'hC9};
    vecs[12] = '{OP_ADC,  16'hFFFF, 16'h0000, 4'd0,  8'h04, 16'h0000, 16'h0000, 8'h45};
    vecs[13] = '{OP_DIV,  16'h0000, 16'h0005, 4'd0,  8'h00, 16'h0000, 16'h0000, 8'h41};
    vecs[14] = '{OP_MUL,  16'h0000, 16'h1234, 4'd0,  8'h00, 16'h0000, 16'h0000, 8'h41};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0;
    a = 16'h0; b = 16'h0; bit_idx = 4'd0; status_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lo", result_lo, 16'h0);
    chk("rst_hi", result_hi, 16'h0);
    chk("rst_status", status_out, 8'h00);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].idx, vecs[i].st, lo, hi, so, lat, nbusy, rib);
      md = (vecs[i].op == OP_MUL) || (vecs[i].op == OP_DIV);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_status", i), so, vecs[i].so);
      chk($sformatf("vec%0d_latency", i), lat, md ? 17 : 1);
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, md ? 16 : 0);
      if (md) chk($sformatf("vec%0d_ready_in_busy", i), rib, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      hso = 8'($urandom);
      hlo = 16'($urandom_range(0, 15));
      run_op(ro, ra, rb, hlo[3:0], hso, lo, hi, so, lat, nbusy, rib);
      model(ro, ra, rb, hlo[3:0], hso, elo, ehi, eso);
      md = (ro == OP_MUL) || (ro == OP_DIV);
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo, elo);
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi, ehi);
      chk($sformatf("rnd%0d_op%0d_status", i, ro), so, eso);
      chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, md ? 17 : 1);
    end

    // Back-pressure: ADD result held while out_ready is low
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    op = OP_ADD; a = 16'h1234; b = 16'h1111; status_in = 8'h08;
    in_valid = 1'b1; out_ready = 1'b0;
    model(OP_ADD, 16'h1234, 16'h1111, 4'd0, 8'h08, elo, ehi, eso);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'h0; b = 16'h0;
    chk("bp_valid", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("bp%0d_lo", k), result_lo, elo);
      chk($sformatf("bp%0d_status", k), status_out, eso);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 1'b0);
    end
    op = OP_INC; a = 16'h00FF; status_in = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    model(OP_INC, 16'h00FF, 16'h0000, 4'd0, 8'h00, elo, ehi, eso);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_lo", result_lo, elo);
    chk("b2b_status", status_out, eso);
    @(posedge clk); #1;
    chk("b2b_drain", out_valid, 1'b0);

    // Reset during BUSY cycle 8 of a MUL
    op = OP_MUL; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_lo", result_lo, 16'h0);
    chk("rstmid_hi", result_hi, 16'h0);
    chk("rstmid_status", status_out, 8'h00);
    chk("rstmid_in_ready", in_ready, 1'b1);
    stale = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("rstmid_no_stale", stale, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
